// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, PCD8544 command constants and init sequence for lcd_frame_ctrl
package lcd_pkg;

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETADDR, FETCH, SEND} state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} tx_state_t;

    localparam logic [7:0] CMD_FUNC_EXT    = 8'h21;
    localparam logic [7:0] CMD_VOP_BASE    = 8'h80;
    localparam logic [7:0] CMD_TEMP        = 8'h04;
    localparam logic [7:0] CMD_BIAS        = 8'h14;
    localparam logic [7:0] CMD_FUNC_BASIC  = 8'h20;
    localparam logic [7:0] CMD_DISP_NORMAL = 8'h0C;
    localparam logic [7:0] CMD_SET_Y0      = 8'h40;
    localparam logic [7:0] CMD_SET_X0      = 8'h80;

    localparam int INIT_LEN = 6;
    localparam logic [7:0] INIT_SEQ [0:INIT_LEN-1] = '{
        CMD_FUNC_EXT, CMD_VOP_BASE, CMD_TEMP, CMD_BIAS, CMD_FUNC_BASIC, CMD_DISP_NORMAL
    };

    // The contrast entry carries the VOP value in its low seven bits.
    function automatic logic [7:0] init_byte(input logic [2:0] i, input logic [6:0] vop);
        return INIT_SEQ[i] | ((i == 3'd1) ? {1'b0, vop} : 8'h00);
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// lcd_byte_tx: one-byte enable/ready handshake towards the spi byte engine
module lcd_byte_tx
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       send,
    input  logic [7:0] tx_byte,
    input  logic       mode,
    input  logic       spi_ready,
    output logic [7:0] spi_data,
    output logic       spi_mode,
    output logic       spi_enable,
    output logic       done
);

    tx_state_t st;

    // Request only while the engine is ready, wait for acceptance, then for completion.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            st         <= TX_IDLE;
            spi_data   <= 8'h00;
            spi_mode   <= 1'b0;
            spi_enable <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                TX_IDLE: if (send && spi_ready) begin
                    spi_data   <= tx_byte;
                    spi_mode   <= mode;
                    spi_enable <= 1'b1;
                    st         <= TX_REQ;
                end
                TX_REQ: if (!spi_ready) begin
                    spi_enable <= 1'b0;
                    st         <= TX_WAIT;
                end
                TX_WAIT: if (spi_ready) begin
                    done <= 1'b1;
                    st   <= TX_IDLE;
                end
                default: st <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_ctrl.sv
// lcd_frame_ctrl: Nokia 5110 power-up, init and framebuffer refresh sequencer.
// Define LCD_FRAME_CTRL_AUTO_REFRESH_EN to add a periodic refresh timer (REFRESH_CYCLES).
module lcd_frame_ctrl
    import lcd_pkg::*;
#(
    parameter int         POWERUP_CYCLES = 1000,
    parameter logic [6:0] VOP            = 7'h3F,
    parameter int         FB_BYTES       = 504
`ifdef LCD_FRAME_CTRL_AUTO_REFRESH_EN
    , parameter int       REFRESH_CYCLES = 1_000_000
`endif
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    output logic       busy,
    output logic       init_done,
    output logic [8:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic [7:0] spi_data,
    output logic       spi_mode,
    output logic       spi_enable,
    input  logic       spi_ready
);

    state_t      state;
    logic        pending;
    logic [31:0] pwr_cnt;
    logic [2:0]  idx;
    logic        go, send, done, tick, tx_mode;
    logic [7:0]  tx_byte;

`ifdef LCD_FRAME_CTRL_AUTO_REFRESH_EN
    logic [31:0] ref_cnt;

    // Free-running refresh timer, started once the panel is initialised.
    always_ff @(posedge clk) begin
        if (!nrst) ref_cnt <= '0;
        else if (init_done) ref_cnt <= (ref_cnt == 32'(REFRESH_CYCLES - 1)) ? '0 : ref_cnt + 1;
    end

    assign tick = init_done && (ref_cnt == 32'(REFRESH_CYCLES - 1));
`else
    assign tick = 1'b0;
`endif

    // Byte selection; the first address byte is offered straight from IDLE so enable rises one cycle after start.
    always_comb begin
        go      = (state == IDLE) && (start || pending);
        send    = go || ((state == INIT || state == SETADDR || state == SEND) && !done);
        tx_mode = (state == SEND);
        tx_byte = (state == INIT) ? init_byte(idx, VOP) :
                  (state == SEND) ? fb_data :
                  (state == SETADDR && idx == 3'd1) ? CMD_SET_X0 : CMD_SET_Y0;
    end

    // Main sequencer: power-up wait, init commands, address set and frame streaming.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= PWRUP;
            busy      <= 1'b1;
            init_done <= 1'b0;
            fb_addr   <= '0;
            pending   <= 1'b0;
            pwr_cnt   <= '0;
            idx       <= '0;
        end else begin
            pending <= tick || ((start || pending) && state != IDLE);
            case (state)
                PWRUP: begin
                    if (pwr_cnt == 32'(POWERUP_CYCLES - 1)) state <= INIT;
                    else pwr_cnt <= pwr_cnt + 1;
                end
                INIT: if (done) begin
                    if (idx == 3'(INIT_LEN - 1)) begin
                        idx       <= '0;
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else idx <= idx + 1;
                end
                IDLE: if (go) begin
                    busy  <= 1'b1;
                    state <= SETADDR;
                end
                SETADDR: if (done) begin
                    if (idx == 3'd1) begin
                        idx     <= '0;
                        fb_addr <= '0;
                        state   <= FETCH;
                    end else idx <= idx + 1;
                end
                FETCH: state <= SEND;
                SEND: if (done) begin
                    if (fb_addr == 9'(FB_BYTES - 1)) begin
                        fb_addr <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        fb_addr <= fb_addr + 1;
                        state   <= FETCH;
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end

    lcd_byte_tx u_tx (
        .clk        (clk),
        .nrst       (nrst),
        .send       (send),
        .tx_byte    (tx_byte),
        .mode       (tx_mode),
        .spi_ready  (spi_ready),
        .spi_data   (spi_data),
        .spi_mode   (spi_mode),
        .spi_enable (spi_enable),
        .done       (done)
    );

endmodule

// File: doc/lcd_frame_ctrl.md
Name: lcd_frame_ctrl

Overview:
Sequencer between the Nokia 5110 SPI byte engine (`spi`) and a 504-byte display framebuffer. After reset it waits for LCD power-up and sends the PCD8544 init command sequence. On each refresh request it sets the RAM address to (X=0, Y=0) and streams all 504 framebuffer bytes as data. It is the only master driving `spi` data/mode/enable.

Parameters:
- POWERUP_CYCLES, 1000: clk cycles to wait after reset release before the first init byte; minimum 1.
- VOP, 7'h3F: contrast value; sent as 0x80|VOP.
- FB_BYTES, 504: frame length in bytes (84x48/8).

Ports:
- clk  in  1  system clock
- nrst  in  1  synchronous active-low reset
- start  in  1  refresh request; single-cycle pulse or level
- busy  out  1  high while init or refresh is in progress
- init_done  out  1  sticky high once the init sequence has completed
- fb_addr  out  9  framebuffer read address, 0..FB_BYTES-1
- fb_data  in  8  framebuffer read data; valid 1 cycle after fb_addr
- spi_data  out  8  byte to `spi` data
- spi_mode  out  1  to `spi` mode; 0 = command (DC low), 1 = data
- spi_enable  out  1  to `spi` enable
- spi_ready  in  1  from `spi` ready

Behaviour:
- Reset (nrst low at a clk edge) forces:
  - outputs: busy=1, init_done=0, fb_addr=0, spi_data=0, spi_mode=0, spi_enable=0
  - internal: pending=0, state=PWRUP, powerup counter=0.
- Byte handshake, identical for every byte:
  - TX_REQ: drive spi_data/spi_mode, assert spi_enable; hold until spi_ready is sampled low (accepted).
  - TX_WAIT: spi_enable=0; wait until spi_ready is sampled high. The byte is then complete.
  - spi_data and spi_mode stay stable from TX_REQ entry until completion.
  - TX_REQ is never entered while spi_ready is low; the block waits for ready high first.
- Main FSM states:
  - PWRUP: count POWERUP_CYCLES, then go to INIT.
  - INIT: send the command bytes 0x21, 0x80|VOP, 0x04, 0x14, 0x20, 0x0C in order, all with mode=0. After the last completion, set init_done=1 in the next cycle and go to IDLE.
  - IDLE: busy=0. If start or pending is set: clear pending and go to SETADDR.
  - SETADDR: send 0x40 then 0x80, both mode=0. Set fb_addr=0 and go to FETCH.
  - FETCH: one cycle for the RAM read latency, then go to SEND.
  - SEND: send the latched fb_data with mode=1. On completion:
    - if fb_addr == FB_BYTES-1, go to IDLE with fb_addr=0;
    - otherwise increment fb_addr and go to FETCH.
- busy is high in every state except IDLE.
- start arriving while busy (including PWRUP/INIT) sets pending. Multiple starts collapse into one pending refresh.
- start in IDLE in the same cycle the FSM enters IDLE is honoured immediately; there is no lost request.
- fb_addr never exceeds FB_BYTES-1 and does not wrap mid-frame.
- Latency from start in IDLE to the first spi_enable rise is 1 cycle (enter SETADDR, TX_REQ).
- Reset mid-byte drops spi_enable in the same edge. The frame is abandoned and the full power-up plus init sequence repeats.

Optional Feature:
- Macro LCD_FRAME_CTRL_AUTO_REFRESH_EN adds a parameter REFRESH_CYCLES (default 1_000_000).
  - Defined: a free-running counter, reset to 0, sets pending each time it reaches REFRESH_CYCLES-1, then wraps to 0. Counting starts only after init_done.
  - Undefined: no counter; refreshes occur only on start.

Decomposition:
- Package lcd_pkg holds:
  - the main FSM state enum and the tx state enum;
  - command constants CMD_FUNC_EXT=0x21, CMD_VOP_BASE=0x80, CMD_TEMP=0x04, CMD_BIAS=0x14, CMD_FUNC_BASIC=0x20, CMD_DISP_NORMAL=0x0C, CMD_SET_Y0=0x40, CMD_SET_X0=0x80;
  - the init-sequence array and INIT_LEN=6.
- One sub-module, lcd_byte_tx, implements the TX_REQ/TX_WAIT handshake.
  - Inputs: send, byte, mode. Outputs: spi_*, done pulse.
  - The main FSM issues send and waits for done.

Test Plan:
1. Power-up and init, with POWERUP_CYCLES=16 and a behavioural spi model (ready low 20 cycles per byte):
   - no spi_enable before cycle 16 after nrst rises;
   - bytes 0x21, 0xBF, 0x04, 0x14, 0x20, 0x0C appear, all mode=0;
   - init_done rises the cycle after the 6th completion; busy falls.
2. Refresh with fb[i]=i[7:0] and a one-pulse start: 0x40, 0x80 (mode 0), then 504 bytes 0x00..0xFF,0x00..0xF7 (mode 1); busy low afterwards; fb_addr=0.
3. Start pulses at cycle 5 and during INIT:
   - exactly one refresh runs right after init;
   - a start during a frame yields exactly one additional frame (3 starts mid-frame still give 1).
4. Handshake robustness: model ready low 1 cycle vs 50 cycles; also hold ready low at entry to TX_REQ.
   - spi_enable never rises while ready is low;
   - spi_data/spi_mode stay stable until ready returns;
   - byte stream is identical across cases.
5. Reset mid-frame: assert nrst at byte 200 → next edge gives spi_enable=0, busy=1, init_done=0; full init sequence re-sent; no pending refresh.
6. With LCD_FRAME_CTRL_AUTO_REFRESH_EN and REFRESH_CYCLES=30000: two complete frames occur with no start input; no frame starts before init_done.
